// File: rtl/shot_if.sv
// Signal bundle between shot_unit and the rest of the game: ship/heading inputs,
// scan position, collision feedback and the mixer-facing draw/colour outputs.
interface shot_if #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int NUM_SHOTS = 4
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(NUM_SHOTS + 1);

  logic                game_over;
  logic                fire;
  logic                frame_tick;
  logic                collision;
  logic [XW-1:0]       ship_x;
  logic [YW-1:0]       ship_y;
  logic signed [17:0]  sin_val;
  logic signed [17:0]  cos_val;
  logic [XW-1:0]       pxl_x;
  logic [YW-1:0]       pxl_y;
  logic [3:0]          Red;
  logic [3:0]          Green;
  logic [3:0]          Blue;
  logic                Draw;
  logic [CW-1:0]       active_cnt;

  modport master (
    output game_over, fire, frame_tick, collision,
    output ship_x, ship_y, sin_val, cos_val, pxl_x, pxl_y,
    input  Red, Green, Blue, Draw, active_cnt
  );

  modport slave (
    input  game_over, fire, frame_tick, collision,
    input  ship_x, ship_y, sin_val, cos_val, pxl_x, pxl_y,
    output Red, Green, Blue, Draw, active_cnt
  );
endinterface

// File: rtl/shot_unit.sv
// Ship projectile manager: spawns bullets along the ship heading, moves them once
// per frame with screen wrap, expires/kills them, and renders 2x2 squares.
module shot_unit #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int NUM_SHOTS = 4,
  parameter int SPEED     = 6,
  parameter int LIFETIME  = 48,
  parameter int COOLDOWN  = 6
) (
  input  logic  clk,
  input  logic  resetN,
  shot_if.slave bus
);
  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int CW  = $clog2(NUM_SHOTS + 1);
  localparam int IW  = (NUM_SHOTS > 1) ? $clog2(NUM_SHOTS) : 1;
  localparam int PXW = XW + 8;
  localparam int PYW = YW + 8;
  localparam int VW  = 14;
  localparam logic signed [PXW+1:0] X_SPAN   = (PXW+2)'(WIDTH * 256);
  localparam logic signed [PYW+1:0] Y_SPAN   = (PYW+2)'(HEIGHT * 256);
  localparam logic signed [23:0]    SPEED_S  = 24'(SPEED);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_SHOTS - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                state;
  logic [IW-1:0]         upd_idx;
  logic [NUM_SHOTS-1:0]  live;
  logic [NUM_SHOTS-1:0]  hit;
  logic [PXW-1:0]        pos_x [NUM_SHOTS];
  logic [PYW-1:0]        pos_y [NUM_SHOTS];
  logic signed [VW-1:0]  vel_x [NUM_SHOTS];
  logic signed [VW-1:0]  vel_y [NUM_SHOTS];
  logic [7:0]            life  [NUM_SHOTS];
  logic                  fire_d;
  logic                  pend;
  logic [7:0]            cooldown;
  logic                  draw_q;
  logic [CW-1:0]         cnt_q;

  logic                  fire_req;
  logic                  do_spawn;
  logic                  kill;
  logic                  free_found;
  logic [IW-1:0]         free_idx;
  logic [NUM_SHOTS-1:0]  hit_next;
  logic [CW-1:0]         live_count;
  logic signed [23:0]    prod_x;
  logic signed [23:0]    prod_y;
  logic signed [23:0]    prod_y_neg;
  logic signed [VW-1:0]  spawn_vx;
  logic signed [VW-1:0]  spawn_vy;
  logic signed [PXW+1:0] nx_raw;
  logic signed [PXW+1:0] nx_fix;
  logic signed [PYW+1:0] ny_raw;
  logic signed [PYW+1:0] ny_fix;

  // Unsigned differences make anything left of / above the bullet a miss, so no wrap here
  function automatic logic covers(input logic [XW-1:0] bx, input logic [YW-1:0] by,
                                  input logic [XW-1:0] px, input logic [YW-1:0] py);
    logic [XW:0] dx;
    logic [YW:0] dy;
    dx = {1'b0, px} - {1'b0, bx};
    dy = {1'b0, py} - {1'b0, by};
    return (dx <= (XW+1)'(1)) && (dy <= (YW+1)'(1));
  endfunction

  assign fire_req = bus.fire && !fire_d && !bus.game_over && (cooldown == 8'd0);
  assign do_spawn = pend && (state == IDLE) && free_found && !bus.game_over;
  assign kill     = bus.collision && draw_q;

  assign prod_x     = 24'(bus.sin_val) * SPEED_S;
  assign prod_y     = 24'(bus.cos_val) * SPEED_S;
  assign prod_y_neg = -prod_y;
  assign spawn_vx   = VW'(prod_x >>> 8);
  assign spawn_vy   = VW'(prod_y_neg >>> 8);

  assign nx_raw = $signed({2'b00, pos_x[upd_idx]}) + (PXW+2)'(vel_x[upd_idx]);
  assign ny_raw = $signed({2'b00, pos_y[upd_idx]}) + (PYW+2)'(vel_y[upd_idx]);

  always_comb begin
    nx_fix = nx_raw;
    if (nx_raw[PXW+1])
      nx_fix = nx_raw + X_SPAN;
    else if (nx_raw >= X_SPAN)
      nx_fix = nx_raw - X_SPAN;
    ny_fix = ny_raw;
    if (ny_raw[PYW+1])
      ny_fix = ny_raw + Y_SPAN;
    else if (ny_raw >= Y_SPAN)
      ny_fix = ny_raw - Y_SPAN;
  end

  // Descending scan so the lowest free index is the one left standing
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) begin
      if (!live[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    hit_next   = '0;
    live_count = '0;
    for (int i = 0; i < NUM_SHOTS; i++) begin
      hit_next[i] = live[i] && !bus.game_over &&
                    covers(pos_x[i][PXW-1:8], pos_y[i][PYW-1:8], bus.pxl_x, bus.pxl_y);
      live_count  = live_count + CW'(live[i]);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      upd_idx  <= '0;
      live     <= '0;
      hit      <= '0;
      fire_d   <= 1'b0;
      pend     <= 1'b0;
      cooldown <= 8'd0;
      draw_q   <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < NUM_SHOTS; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= '0;
        vel_y[i] <= '0;
        life[i]  <= 8'd0;
      end
    end else begin
      fire_d <= bus.fire;
      hit    <= hit_next;
      draw_q <= |hit_next;
      cnt_q  <= live_count;

      if (do_spawn)
        cooldown <= 8'(COOLDOWN);
      else if (bus.frame_tick && cooldown != 8'd0)
        cooldown <= cooldown - 8'd1;

      if (bus.game_over)
        pend <= 1'b0;
      else if (fire_req)
        pend <= 1'b1;
      else if (state == IDLE)
        pend <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.frame_tick) begin
            state   <= UPDATE;
            upd_idx <= '0;
          end
        end
        UPDATE: begin
          if (upd_idx == LAST_IDX)
            state <= IDLE;
          else
            upd_idx <= upd_idx + IW'(1);
        end
        default: state <= IDLE;
      endcase

      // Kill outranks the frame update; spawn only ever lands on a slot that was free
      for (int i = 0; i < NUM_SHOTS; i++) begin
        if (bus.game_over) begin
          live[i] <= 1'b0;
        end else if (kill && hit[i]) begin
          live[i] <= 1'b0;
        end else if (do_spawn && free_idx == IW'(i)) begin
          live[i]  <= 1'b1;
          pos_x[i] <= {bus.ship_x, 8'h00};
          pos_y[i] <= {bus.ship_y, 8'h00};
          vel_x[i] <= spawn_vx;
          vel_y[i] <= spawn_vy;
          life[i]  <= 8'(LIFETIME);
        end else if (state == UPDATE && upd_idx == IW'(i) && live[i]) begin
          life[i] <= life[i] - 8'd1;
          if (life[i] == 8'd1) begin
            live[i] <= 1'b0;
          end else begin
            pos_x[i] <= PXW'(nx_fix);
            pos_y[i] <= PYW'(ny_fix);
          end
        end
      end
    end
  end

  assign bus.Draw       = draw_q;
  assign bus.Red        = {4{draw_q}};
  assign bus.Green      = {4{draw_q}};
  assign bus.Blue       = {4{draw_q}};
  assign bus.active_cnt = cnt_q;
endmodule

// File: tb/tb_shot_unit.sv
// Randomized self-checking bench for shot_unit against a frame-level bullet model.
module tb_shot_unit;
  localparam int W = 640, H = 480, N = 4, SPD = 6, LIFE = 48, COOL = 6;
  localparam int XSPAN = W * 256, YSPAN = H * 256;

  logic clk = 1'b0;
  logic resetN;
  int   checks = 0;
  int   failures = 0;

  bit m_live [N];
  int m_x [N], m_y [N], m_vx [N], m_vy [N], m_life [N];
  int m_cool;

  shot_if #(.WIDTH(W), .HEIGHT(H), .NUM_SHOTS(N)) bus ();

  shot_unit #(.WIDTH(W), .HEIGHT(H), .NUM_SHOTS(N), .SPEED(SPD),
              .LIFETIME(LIFE), .COOLDOWN(COOL))
    dut (.clk(clk), .resetN(resetN), .bus(bus.slave));

  always #5 clk = ~clk;

  function automatic int floor256(longint v);
    if (v >= 0) return int'(v / 256);
    return -int'((-v + 255) / 256);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_live[i] = 1'b0;
    m_cool = 0;
  endfunction

  function automatic void model_fire(int sx, int sy, int s, int c);
    if (m_cool != 0) return;
    for (int i = 0; i < N; i++) begin
      if (!m_live[i]) begin
        m_live[i] = 1'b1;
        m_x[i] = sx * 256;
        m_y[i] = sy * 256;
        m_vx[i] = floor256(longint'(s) * SPD);
        m_vy[i] = floor256(-(longint'(c) * SPD));
        m_life[i] = LIFE;
        m_cool = COOL;
        return;
      end
    end
  endfunction

  function automatic void model_frame();
    if (m_cool > 0) m_cool--;
    for (int i = 0; i < N; i++) begin
      if (m_live[i]) begin
        m_life[i]--;
        if (m_life[i] == 0) m_live[i] = 1'b0;
        else begin
          m_x[i] = ((m_x[i] + m_vx[i]) % XSPAN + XSPAN) % XSPAN;
          m_y[i] = ((m_y[i] + m_vy[i]) % YSPAN + YSPAN) % YSPAN;
        end
      end
    end
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < N; i++) if (m_live[i]) n++;
    return n;
  endfunction

  function automatic bit model_draw(int px, int py);
    for (int i = 0; i < N; i++)
      if (m_live[i] && px >= m_x[i] / 256 && px <= m_x[i] / 256 + 1 &&
          py >= m_y[i] / 256 && py <= m_y[i] / 256 + 1) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic park();
    bus.pxl_x = 10'd0;
    bus.pxl_y = 9'd470;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    bus.game_over = 1'b0; bus.fire = 1'b0; bus.frame_tick = 1'b0; bus.collision = 1'b0;
    bus.ship_x = '0; bus.ship_y = '0; bus.sin_val = '0; bus.cos_val = 18'sd65536;
    park();
    step(2);
    resetN = 1'b1;
    step(1);
    model_clear();
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(N + 2);
    model_frame();
  endtask

  task automatic shoot(input int sx, input int sy, input int s, input int c);
    bus.ship_x = 10'(sx); bus.ship_y = 9'(sy);
    bus.sin_val = 18'(s); bus.cos_val = 18'(c);
    bus.fire = 1'b1;
    step(4);
    bus.fire = 1'b0;
    step(2);
    model_fire(sx, sy, s, c);
  endtask

  task automatic probe(input int px, input int py, output logic d);
    bus.pxl_x = 10'(px);
    bus.pxl_y = 9'(py);
    step(1);
    d = bus.Draw;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #1;
    checks++;
    if (bus.Draw !== 1'b0 || bus.active_cnt !== 3'd0 || {bus.Red, bus.Green, bus.Blue} !== 12'h000) begin
      failures++;
      $display("[TB] FAIL reset_state: draw=%b cnt=%0d rgb=%h required 0/0/000",
               bus.Draw, bus.active_cnt, {bus.Red, bus.Green, bus.Blue});
    end
    do_reset();
    for (int k = 0; k < 1000; k++) begin
      bus.pxl_x = 10'($urandom_range(0, W - 1));
      bus.pxl_y = 9'($urandom_range(0, H - 1));
      bus.frame_tick = ($urandom_range(0, 49) == 0);
      step(1);
      checks++;
      if (bus.Draw !== 1'b0 || bus.active_cnt !== 3'd0) begin
        failures++;
        $display("[TB] FAIL idle: draw=%b cnt=%0d required 0/0 at cycle %0d", bus.Draw, bus.active_cnt, k);
      end
    end
    bus.frame_tick = 1'b0;
    step(N + 2);
  endtask

  task automatic test_fire_up();
    logic d;
    do_reset();
    shoot(320, 240, 0, 65536);
    checks++;
    if (bus.active_cnt !== 3'd1) begin
      failures++; $display("[TB] FAIL up_count: got %0d required 1", bus.active_cnt);
    end
    probe(320, 240, d);
    checks++;
    if (d !== 1'b1) begin failures++; $display("[TB] FAIL up_spawn_pos: draw=%b required 1", d); end
    repeat (3) frame();
    probe(320, 222, d);
    checks++;
    if (d !== 1'b1 || {bus.Red, bus.Green, bus.Blue} !== 12'hFFF) begin
      failures++; $display("[TB] FAIL up_320_222: draw=%b rgb=%h required 1/fff", d, {bus.Red, bus.Green, bus.Blue});
    end
    probe(321, 223, d);
    checks++;
    if (d !== 1'b1) begin failures++; $display("[TB] FAIL up_321_223: draw=%b required 1", d); end
    probe(322, 222, d);
    checks++;
    if (d !== 1'b0 || {bus.Red, bus.Green, bus.Blue} !== 12'h000) begin
      failures++; $display("[TB] FAIL up_322_222: draw=%b rgb=%h required 0/000", d, {bus.Red, bus.Green, bus.Blue});
    end
    probe(320, 224, d);
    checks++;
    if (d !== 1'b0) begin failures++; $display("[TB] FAIL up_320_224: draw=%b required 0", d); end
    park();
  endtask

  task automatic test_wrap_expiry();
    logic d;
    do_reset();
    shoot(636, 100, 65536, 0);
    frame();
    probe(2, 100, d);
    checks++;
    if (d !== 1'b1) begin failures++; $display("[TB] FAIL wrap_x2: draw=%b required 1", d); end
    probe(636, 100, d);
    checks++;
    if (d !== 1'b0) begin failures++; $display("[TB] FAIL wrap_old: draw=%b required 0", d); end
    park();
    repeat (LIFE - 2) frame();
    checks++;
    if (bus.active_cnt !== 3'd1) begin
      failures++; $display("[TB] FAIL life_47: cnt=%0d required 1", bus.active_cnt);
    end
    frame();
    checks++;
    if (bus.active_cnt !== 3'd0) begin
      failures++; $display("[TB] FAIL life_48: cnt=%0d required 0", bus.active_cnt);
    end
  endtask

  task automatic test_saturation();
    logic d;
    int exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      shoot($urandom_range(0, W - 1), $urandom_range(0, H - 1),
            int'($urandom_range(0, 131072)) - 65536, int'($urandom_range(0, 131072)) - 65536);
      exp = (k < N) ? k + 1 : N;
      checks++;
      if (bus.active_cnt !== 3'(exp) || model_count() != exp) begin
        failures++; $display("[TB] FAIL sat_count%0d: cnt=%0d required %0d", k, bus.active_cnt, exp);
      end
      for (int i = 0; i < N; i++) begin
        if (m_live[i]) begin
          probe(m_x[i] / 256, m_y[i] / 256, d);
          checks++;
          if (d !== 1'b1) begin failures++; $display("[TB] FAIL sat_draw%0d_%0d: draw=%b required 1", k, i, d); end
        end
      end
      park();
      repeat (10) frame();
    end
  endtask

  task automatic test_cooldown();
    do_reset();
    shoot(100, 100, 0, 65536);
    repeat (2) frame();
    shoot(200, 200, 0, 65536);
    checks++;
    if (bus.active_cnt !== 3'd1) begin failures++; $display("[TB] FAIL cool_2f: cnt=%0d required 1", bus.active_cnt); end
    repeat (3) frame();
    shoot(200, 200, 0, 65536);
    checks++;
    if (bus.active_cnt !== 3'd1) begin failures++; $display("[TB] FAIL cool_5f: cnt=%0d required 1", bus.active_cnt); end
    frame();
    shoot(200, 200, 0, 65536);
    checks++;
    if (bus.active_cnt !== 3'd2 || model_count() != 2) begin
      failures++; $display("[TB] FAIL cool_6f: cnt=%0d required 2", bus.active_cnt);
    end
  endtask

  task automatic test_collision();
    logic d;
    do_reset();
    for (int k = 0; k < N; k++) begin
      shoot(60 + 140 * k + $urandom_range(0, 60), 20 + $urandom_range(0, 380), 0, 0);
      repeat (COOL) frame();
    end
    probe(m_x[2] / 256 + 1, m_y[2] / 256, d);
    checks++;
    if (d !== 1'b1) begin failures++; $display("[TB] FAIL kill_pre_draw: draw=%b required 1", d); end
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    park();
    m_live[2] = 1'b0;
    step(1);
    checks++;
    if (bus.active_cnt !== 3'd3) begin failures++; $display("[TB] FAIL kill_count: cnt=%0d required 3", bus.active_cnt); end
    for (int i = 0; i < N; i++) begin
      probe(m_x[i] / 256, m_y[i] / 256, d);
      checks++;
      if (d !== (i != 2)) begin failures++; $display("[TB] FAIL kill_slot%0d: draw=%b required %0d", i, d, i != 2); end
    end
    park();
    step(2);
    bus.collision = 1'b1;
    step(3);
    bus.collision = 1'b0;
    step(2);
    checks++;
    if (bus.active_cnt !== 3'd3) begin failures++; $display("[TB] FAIL nodraw_collide: cnt=%0d required 3", bus.active_cnt); end
  endtask

  task automatic test_game_over();
    logic d;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      shoot(80 + 180 * k + $urandom_range(0, 60), 20 + $urandom_range(0, 380), 0, 0);
      if (k < 2) repeat (COOL) frame();
    end
    probe(m_x[0] / 256, m_y[0] / 256, d);
    checks++;
    if (d !== 1'b1 || bus.active_cnt !== 3'd3) begin
      failures++; $display("[TB] FAIL go_pre: draw=%b cnt=%0d required 1/3", d, bus.active_cnt);
    end
    bus.game_over = 1'b1;
    step(1);
    checks++;
    if (bus.Draw !== 1'b0) begin failures++; $display("[TB] FAIL go_draw: draw=%b required 0", bus.Draw); end
    step(1);
    checks++;
    if (bus.active_cnt !== 3'd0) begin failures++; $display("[TB] FAIL go_clear: cnt=%0d required 0", bus.active_cnt); end
    for (int i = 0; i < N; i++) m_live[i] = 1'b0;
    park();
    bus.fire = 1'b1;
    step(4);
    bus.fire = 1'b0;
    step(2);
    bus.game_over = 1'b0;
    step(3);
    checks++;
    if (bus.active_cnt !== 3'd0) begin failures++; $display("[TB] FAIL go_fire: cnt=%0d required 0", bus.active_cnt); end
    repeat (COOL) frame();
    shoot(300, 300, 0, 65536);
    checks++;
    if (bus.active_cnt !== 3'd1 || model_count() != 1) begin
      failures++; $display("[TB] FAIL go_recover: cnt=%0d required 1", bus.active_cnt);
    end
  endtask

  task automatic test_fire_during_update();
    logic d;
    int sx, sy, s, c;
    do_reset();
    sx = $urandom_range(10, W - 10); sy = $urandom_range(10, H - 10);
    s = int'($urandom_range(0, 131072)) - 65536; c = int'($urandom_range(0, 131072)) - 65536;
    bus.ship_x = 10'(sx); bus.ship_y = 9'(sy); bus.sin_val = 18'(s); bus.cos_val = 18'(c);
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    bus.fire = 1'b1;
    step(5);
    checks++;
    if (bus.active_cnt !== 3'd0) begin failures++; $display("[TB] FAIL upd_early: cnt=%0d required 0", bus.active_cnt); end
    step(1);
    checks++;
    if (bus.active_cnt !== 3'd1) begin failures++; $display("[TB] FAIL upd_spawn: cnt=%0d required 1", bus.active_cnt); end
    bus.fire = 1'b0;
    step(2);
    model_frame();
    model_fire(sx, sy, s, c);
    probe(sx, sy, d);
    checks++;
    if (d !== model_draw(sx, sy)) begin failures++; $display("[TB] FAIL upd_pos: draw=%b required %0d", d, model_draw(sx, sy)); end
    park();
  endtask

  task automatic test_random();
    logic d;
    int r, px, py;
    do_reset();
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 19);
      if (r < 5)
        shoot($urandom_range(0, W - 1), $urandom_range(0, H - 1),
              int'($urandom_range(0, 131072)) - 65536, int'($urandom_range(0, 131072)) - 65536);
      else if (r < 18)
        frame();
      else begin
        bus.game_over = 1'b1;
        step(1);
        bus.game_over = 1'b0;
        step(1);
        for (int i = 0; i < N; i++) m_live[i] = 1'b0;
      end
      step(1);
      checks++;
      if (bus.active_cnt !== 3'(model_count())) begin
        failures++; $display("[TB] FAIL rnd_count%0d: cnt=%0d required %0d", it, bus.active_cnt, model_count());
      end
      for (int i = 0; i < N; i++) begin
        if (m_live[i]) begin
          probe(m_x[i] / 256, m_y[i] / 256, d);
          checks++;
          if (d !== 1'b1) begin failures++; $display("[TB] FAIL rnd_draw%0d_%0d: draw=%b required 1", it, i, d); end
        end
      end
      px = $urandom_range(0, W - 1); py = $urandom_range(0, H - 1);
      probe(px, py, d);
      checks++;
      if (d !== model_draw(px, py)) begin
        failures++; $display("[TB] FAIL rnd_pix%0d (%0d,%0d): draw=%b required %0d", it, px, py, d, model_draw(px, py));
      end
      park();
    end
  endtask

  initial begin
    test_reset();
    test_fire_up();
    test_wrap_expiry();
    test_saturation();
    test_cooldown();
    test_collision();
    test_game_over();
    test_fire_during_update();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
